score_sequencer: RTL and testbench
==================================

# score_sequencer

Sequential score controller between the game-event logic and the score display path. Arbitrates point-award requests from two requesters, accumulates a 0–999 running score, and converts it to three BCD digits with an iterative shift-add-3 engine instead of combinational divide/modulo. Publishes digits with an update strobe to the digit-to-glyph indexing stage.

## Interface
- `SCORE_W`, 10: score register width; values 0–999 only.
- `AMT_W`, 7: award amount width, 0–127.
- `clk` in 1: system clock; all logic on rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `req0` in 1: requester 0 award request; held high until `ack0`.
- `amt0` in AMT_W: requester 0 amount; stable while `req0` high.
- `req1` in 1: requester 1 award request; held high until `ack1`.
- `amt1` in AMT_W: requester 1 amount.
- `ack0` / `ack1` out 1: combinational grant; high for the one cycle the request is accepted.
- `clr` in 1: synchronous score clear (game restart), single-cycle pulse.
- `score` out SCORE_W: binary running score.
- `dig2`, `dig1`, `dig0` out 4 each: BCD hundreds, tens, ones.
- `upd` out 1: one-cycle pulse, digits just changed.
- `ovf` out 1: one-cycle pulse, last award exceeded 999.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, ACCUM, CONV, PUB.
- IDLE: if `clr` high, clear (see below). Else if any request: grant one, latch its amount, go ACCUM. Else stay.
- Arbitration: round-robin with one `last` bit. Only one request pending → grant it. Both pending → grant the requester not granted last. `last` resets to 1, so requester 0 wins the first tie.
- `ack` is asserted only in IDLE, only to the granted requester, and only when `clr` is low.
- ACCUM: sum = score + amt in 11 bits. If sum > 999, pulse `ovf` next cycle and apply the overflow rule (Configuration). Load the new score into the BCD shift register with the BCD field zeroed and counter=0. Go CONV.
- CONV: 10 iterations, one per cycle. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts left by one, taking the next binary MSB. Go PUB after the 10th.
- PUB: copy the BCD nibbles to `dig2..dig0`, pulse `upd`, return to IDLE.
- Amount 0 is legal: runs the full sequence and republishes unchanged digits with `upd`.
- `clr` has the highest priority in every state. It aborts any in-flight operation: score ← 0, digits ← 0, `upd` pulses next cycle, `ovf` stays low, state ← IDLE, `last` unchanged. A request present in the same cycle is not acked.
- Requests arriving while `busy` wait; no acks are given outside IDLE.
- Reset values: score 0, dig2/dig1/dig0 0, upd 0, ovf 0, busy 0, ack0/ack1 0, state IDLE.

## Timing
- Ack in cycle T.
- ACCUM is T+1; `score` shows the new value from T+2. `ovf` is high in T+2 if applicable.
- CONV is T+2..T+11; PUB is T+12.
- Digits change and `upd` is high in T+13; `busy` is low in T+13.
- Earliest next ack is T+13 (IDLE again).
- Throughput: one award per 13 cycles.
- `clr` in cycle C: score/digits are 0 and `upd` is high in C+1. The earliest ack is in C+1.
- `score` and digits hold between updates; `upd` is never high two cycles in a row except clr directly after a PUB.

## Configuration
- `SCORE_SAT_EN` defined: sum > 999 saturates, score ← 999.
- `SCORE_SAT_EN` undefined: sum > 999 wraps, score ← sum − 1000.
- `ovf` pulses in both builds.

## Test plan
- Reset: hold `resetn`=0 for 3 cycles with `req0`=1 → all outputs 0, no ack. Release → `ack0` in the first IDLE cycle.
- Single award: `req0`, `amt0`=57 from score 0 → `ack0` at T, `score`=57 at T+2, digits 0/5/7 with `upd` at T+13.
- Tie: `req0` and `req1` held continuously with amounts 1 and 2 → acks alternate 0,1,0,1, 13 cycles apart, score 1,3,4,6.
- Overflow: score 990, award 20 → `ovf` at T+2. With `SCORE_SAT_EN`: digits 9/9/9. Without: digits 0/1/0.
- Clear mid-convert: award 100, `clr` at T+5 → at T+6 score 0, digits 0/0/0, `upd`=1, busy=0; no `upd` at T+13.
- Back-to-back: 10 awards of 127 from 0 → score 999 (sat build) or 270 (wrap build), one `ovf` per crossing, digits match score after each `upd`.

Source files
------------

// File: rtl/score_sequencer.sv
// Two-requester point accumulator (0-999) with iterative shift-add-3 BCD conversion; SCORE_SAT_EN selects saturate over wrap.
// Latency: ack at T, score at T+2, digits and upd at T+13; clr takes effect next cycle.
// Backpressure: requests hold until acked; acks only in IDLE with clr low, so one award per 13 cycles.
module score_sequencer #(
   parameter int SCORE_W = 10,
   parameter int AMT_W   = 7
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               req0,
   input  logic [AMT_W-1:0]   amt0,
   input  logic               req1,
   input  logic [AMT_W-1:0]   amt1,
   output logic               ack0,
   output logic               ack1,
   input  logic               clr,
   output logic [SCORE_W-1:0] score,
   output logic [3:0]         dig2,
   output logic [3:0]         dig1,
   output logic [3:0]         dig0,
   output logic               upd,
   output logic               ovf,
   output logic               busy
);
   localparam int BCD_W = 12;
   localparam int SR_W  = BCD_W + SCORE_W;

   typedef enum logic [1:0] {IDLE, ACCUM, CONV, PUB} state_t;

   state_t             state, state_nxt;
   logic               last;
   logic [AMT_W-1:0]   amt_q;
   logic [SCORE_W:0]   sum;
   logic               sum_ovf;
   logic [SCORE_W-1:0] sum_fix;
   logic [SR_W-1:0]    sr, sr_adj, sr_nxt;
   logic [3:0]         cnt;
   logic               grant0, grant1;

   // last holds the index of the most recent grant; ties go to the other requester
   always_comb begin
      grant0 = req0 && (!req1 || last);
      grant1 = req1 && (!req0 || !last);
   end

   always_comb begin
      sum     = {1'b0, score} + (SCORE_W+1)'(amt_q);
      sum_ovf = sum > (SCORE_W+1)'(999);
      sum_fix = sum[SCORE_W-1:0];
      if (sum_ovf) begin
`ifdef SCORE_SAT_EN
         sum_fix = SCORE_W'(999);
`else
         sum_fix = SCORE_W'(sum - (SCORE_W+1)'(1000));
`endif
      end
   end

   always_comb begin
      sr_adj = sr;
      for (int i = 0; i < 3; i++) begin
         if (sr[SCORE_W+4*i +: 4] >= 4'd5)
            sr_adj[SCORE_W+4*i +: 4] = sr[SCORE_W+4*i +: 4] + 4'd3;
      end
      sr_nxt = sr_adj << 1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ack0      = 1'b0;
      ack1      = 1'b0;
      busy      = (state != IDLE);
      if (clr) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (resetn && (grant0 || grant1)) begin
                  ack0      = grant0;
                  ack1      = grant1;
                  state_nxt = ACCUM;
               end
            end
            ACCUM:   state_nxt = CONV;
            CONV:    if (cnt == 4'(SCORE_W-1)) state_nxt = PUB;
            PUB:     state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         score <= '0;
         dig2  <= '0;
         dig1  <= '0;
         dig0  <= '0;
         upd   <= 1'b0;
         ovf   <= 1'b0;
         last  <= 1'b1;
         amt_q <= '0;
         sr    <= '0;
         cnt   <= '0;
      end else begin
         upd <= 1'b0;
         ovf <= 1'b0;
         if (clr) begin
            score <= '0;
            dig2  <= '0;
            dig1  <= '0;
            dig0  <= '0;
            upd   <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (ack0) begin
                     amt_q <= amt0;
                     last  <= 1'b0;
                  end else if (ack1) begin
                     amt_q <= amt1;
                     last  <= 1'b1;
                  end
               end
               ACCUM: begin
                  score <= sum_fix;
                  ovf   <= sum_ovf;
                  sr    <= {{BCD_W{1'b0}}, sum_fix};
                  cnt   <= '0;
               end
               CONV: begin
                  sr  <= sr_nxt;
                  cnt <= cnt + 4'd1;
               end
               PUB: begin
                  dig2 <= sr[SCORE_W+8 +: 4];
                  dig1 <= sr[SCORE_W+4 +: 4];
                  dig0 <= sr[SCORE_W   +: 4];
                  upd  <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_score_sequencer.sv
// Bench for score_sequencer: transaction-level score model checked every cycle plus directed literal expectations.
module tb_score_sequencer;
`ifdef SCORE_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       resetn, req0, req1, clr;
   logic [6:0] amt0, amt1;
   logic       ack0, ack1, upd, ovf, busy;
   logic [9:0] score;
   logic [3:0] dig2, dig1, dig0;

   int errors = 0;
   int checks = 0;

   score_sequencer dut (
      .clk(clk), .resetn(resetn),
      .req0(req0), .amt0(amt0), .req1(req1), .amt1(amt1),
      .ack0(ack0), .ack1(ack1), .clr(clr),
      .score(score), .dig2(dig2), .dig1(dig1), .dig0(dig0),
      .upd(upd), .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: m_t counts cycles since the grant (0 = idle); m_dig is the published value.
   int m_score = 0, m_dig = 0, m_t = 0, m_amt = 0;
   bit m_upd = 0, m_ovf = 0, m_last = 1;

   function automatic bit e_ack0();
      return resetn && m_t == 0 && !clr && req0 && (!req1 || m_last);
   endfunction
   function automatic bit e_ack1();
      return resetn && m_t == 0 && !clr && req1 && (!req0 || !m_last);
   endfunction

   always @(posedge clk) begin
      bit a0, a1;
      int s;
      a0 = e_ack0();
      a1 = e_ack1();
      if (!resetn) begin
         m_score = 0; m_dig = 0; m_upd = 0; m_ovf = 0; m_t = 0; m_last = 1;
      end else begin
         m_upd = 0;
         m_ovf = 0;
         if (clr) begin
            m_score = 0; m_dig = 0; m_upd = 1; m_t = 0;
         end else if (m_t == 0) begin
            if (a0) begin m_amt = amt0; m_last = 0; m_t = 1; end
            else if (a1) begin m_amt = amt1; m_last = 1; m_t = 1; end
         end else begin
            m_t++;
            if (m_t == 2) begin
               s = m_score + m_amt;
               if (s > 999) begin
                  m_ovf = 1;
                  s = SAT ? 999 : s - 1000;
               end
               m_score = s;
            end
            if (m_t == 13) begin
               m_dig = m_score; m_upd = 1; m_t = 0;
            end
         end
      end
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         check("score", score, m_score);
         check("dig2", dig2, m_dig / 100);
         check("dig1", dig1, (m_dig / 10) % 10);
         check("dig0", dig0, m_dig % 10);
         check("upd", upd, m_upd);
         check("ovf", ovf, m_ovf);
         check("busy", busy, m_t != 0);
         check("ack0", ack0, e_ack0());
         check("ack1", ack1, e_ack1());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input int budget, output int who, output int cyc);
      who = -1;
      cyc = 0;
      while (cyc < budget) begin
         #1;
         if (ack0) begin who = 0; break; end
         if (ack1) begin who = 1; break; end
         tick();
         cyc++;
      end
      if (who < 0) begin
         errors++;
         checks++;
         $display("FAIL ack_timeout: no ack within %0d cycles", budget);
      end
   endtask

   task automatic do_award(input int who, input int amt, output bit saw_ovf);
      int w, c;
      if (who == 0) begin req0 = 1; amt0 = 7'(amt); end
      else begin req1 = 1; amt1 = 7'(amt); end
      wait_ack(40, w, c);
      check("award_who", w, who);
      tick();
      req0 = 0; req1 = 0;
      tick();
      #1;
      saw_ovf = ovf;
      repeat (11) tick();
      #1;
   endtask

   task automatic do_clr();
      clr = 1;
      tick();
      clr = 0;
   endtask

   initial begin
      int exp_who[4]  = '{0, 1, 0, 1};
      int exp_prev[4] = '{0, 1, 3, 4};
      int who, cyc, novf;
      bit saw;

      resetn = 0; req0 = 1; amt0 = 57; req1 = 0; amt1 = 0; clr = 0;
      repeat (3) tick();
      #1;
      check("rst_ack0", ack0, 0);
      check("rst_score", score, 0);
      check("rst_busy", busy, 0);
      check("rst_upd", upd, 0);
      resetn = 1;
      #1;
      check("rel_ack0", ack0, 1);
      tick();
      req0 = 0;
      tick();
      #1;
      check("single_score", score, 57);
      repeat (11) tick();
      #1;
      check("single_upd", upd, 1);
      check("single_busy", busy, 0);
      check("single_d2", dig2, 0);
      check("single_d1", dig1, 5);
      check("single_d0", dig0, 7);

      // Reset restores last, then clr with both requests pending must not ack.
      resetn = 0;
      tick();
      resetn = 1; clr = 1; req0 = 1; req1 = 1; amt0 = 1; amt1 = 2;
      #1;
      check("clr_noack0", ack0, 0);
      check("clr_noack1", ack1, 0);
      tick();
      clr = 0;
      for (int k = 0; k < 4; k++) begin
         wait_ack(40, who, cyc);
         check("tie_who", who, exp_who[k]);
         check("tie_prev_score", score, exp_prev[k]);
         if (k > 0) check("tie_gap", cyc + 1, 13);
         else       check("clr_ack_lat", cyc, 0);
         tick();
      end
      req0 = 0; req1 = 0;
      repeat (12) tick();
      #1;
      check("tie_score", score, 6);
      check("tie_d0", dig0, 6);
      check("tie_upd", upd, 1);

      do_clr();
      novf = 0;
      for (int k = 0; k < 10; k++) begin
         do_award(0, 127, saw);
         novf += saw;
      end
      check("b2b_score", score, SAT ? 999 : 270);
      check("b2b_ovf_count", novf, SAT ? 3 : 1);
      check("b2b_d1", dig1, SAT ? 9 : 7);

      do_clr();
      for (int k = 0; k < 7; k++) do_award(k % 2, 127, saw);
      do_award(1, 101, saw);
      check("pre_ovf_score", score, 990);
      do_award(0, 20, saw);
      check("ovf_pulse", saw, 1);
      check("ovf_score", score, SAT ? 999 : 10);
      check("ovf_d2", dig2, SAT ? 9 : 0);
      check("ovf_d1", dig1, SAT ? 9 : 1);
      check("ovf_d0", dig0, SAT ? 9 : 0);

      do_clr();
      req0 = 1; amt0 = 100;
      wait_ack(40, who, cyc);
      check("mid_who", who, 0);
      tick();
      req0 = 0;
      repeat (4) tick();
      clr = 1;
      tick();
      clr = 0;
      #1;
      check("mid_score", score, 0);
      check("mid_upd", upd, 1);
      check("mid_busy", busy, 0);
      check("mid_d2", dig2, 0);
      repeat (7) tick();
      #1;
      check("mid_no_upd", upd, 0);
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
